// File: rtl/stop_frame_ctrl_if.sv
// Frame controller bus: start/strobe control, shift-register hookup and the parallel-word handshake.
// "master" is the controller side, "slave" the environment that feeds bits and consumes words.
interface stop_frame_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic             bit_stb;
    logic [WIDTH-1:0] sreg_q;
    logic             shift_en;
    logic [WIDTH-1:0] pout;
    logic             pout_valid;
    logic             pout_ready;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;
    logic             parity_bit;
    logic             parity_err;

    modport master (
        input  start, bit_stb, sreg_q, pout_ready, ovr_clr, parity_bit,
        output shift_en, pout, pout_valid, busy, overrun, parity_err
    );

    modport slave (
        output start, bit_stb, sreg_q, pout_ready, ovr_clr, parity_bit,
        input  shift_en, pout, pout_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/stop_frame_ctrl.sv
// Sequences an external WIDTH-bit shift register: gates shift_en per bit, captures the word and
// hands it downstream on valid/ready. Optional even-parity check enabled by `define PARITY_CHECK_EN.
module stop_frame_ctrl #(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst,
    stop_frame_ctrl_if.master bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] Full = CW'(WIDTH);
`ifdef PARITY_CHECK_EN
    // The parity strobe is the one arriving once all data bits are in.
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {StIdle, StShift, StCapt} state_e;

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] pout_q;
    logic             pout_valid_q;
    logic             overrun_q;
    logic             busy_q;
    logic             cap_ok;
    logic             ovr_set;
    logic             last_stb;

    assign cap_ok   = !pout_valid_q || bus.pout_ready;
    assign ovr_set  = (state_q == StCapt) && !cap_ok;
    assign last_stb = (state_q == StShift) && !bus.start && bus.bit_stb && (cnt_q == LastCnt);

    // A restart strobe and the parity strobe never shift.
    assign bus.shift_en = !rst && (state_q == StShift) && bus.bit_stb && !bus.start &&
                          (cnt_q != Full);

    assign bus.pout       = pout_q;
    assign bus.pout_valid = pout_valid_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pout_q       <= '0;
            pout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StShift: begin
                    if (bus.start) begin
                        cnt_q <= '0;
                    end else if (bus.bit_stb) begin
                        if (cnt_q != Full) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                        if (last_stb) begin
                            state_q <= StCapt;
                        end
                    end
                end
                StCapt: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase

            // A capture may coincide with a transfer; the new word then stays valid.
            if (state_q == StCapt) begin
                if (cap_ok) begin
                    pout_q       <= bus.sreg_q;
                    pout_valid_q <= 1'b1;
                end
            end else if (pout_valid_q && bus.pout_ready) begin
                pout_valid_q <= 1'b0;
            end

            if (ovr_set) begin
                overrun_q <= 1'b1;
            end else if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

`ifdef PARITY_CHECK_EN
    logic par_q;
    logic perr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (last_stb) begin
                par_q <= bus.parity_bit;
            end
            if ((state_q == StCapt) && cap_ok) begin
                perr_q <= (^bus.sreg_q) ^ par_q;
            end
        end
    end

    assign bus.parity_err = perr_q;
`else
    logic unused_parity;
    assign unused_parity  = bus.parity_bit;
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_stop_frame_ctrl.sv
// Directed bench for stop_frame_ctrl with WIDTH=4; models the external shift register.
module tb_stop_frame_ctrl;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic [W-1:0] sreg;
    int           total = 0;
    int           bad = 0;
    int           sh_cnt = 0;
    int           base;

    stop_frame_ctrl_if #(.WIDTH(W)) bus ();
    stop_frame_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.sreg_q = sreg;

    // Shift-left register, serial bit enters bit 0.
    always @(posedge clk) begin
        if (rst) sreg <= '0;
        else if (bus.shift_en) sreg <= {sreg[W-2:0], sin};
        if (bus.shift_en) sh_cnt <= sh_cnt + 1;
    end

    typedef struct {
        logic       r, s, b, d, rd, c;
        logic       sh, busy, val;
        logic [3:0] pout;
        logic       ovr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic r, input logic s, input logic b, input logic d,
                       input logic rd, input logic c);
        rst = r; bus.start = s; bus.bit_stb = b; sin = d; bus.pout_ready = rd; bus.ovr_clr = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start, data MSB first, optional parity strobe, CAPT cycle with the given ready.
    task automatic send_frame(input logic [3:0] data, input logic par, input logic rdy_capt);
        bus.parity_bit = par;
        drv(0, 1, 0, 0, 0, 0); tick();
        for (int i = W - 1; i >= 0; i--) begin
            drv(0, 0, 1, data[i], 0, 0); tick();
        end
`ifdef PARITY_CHECK_EN
        drv(0, 0, 1, 0, 0, 0); tick();
`endif
        drv(0, 0, 0, 0, rdy_capt, 0); tick();
        drv(0, 0, 0, 0, 0, 0);
        bus.parity_bit = 1'b0;
    endtask

    initial begin
        vec_t tbl[24];
        bus.parity_bit = 1'b0;
        drv(1, 0, 0, 0, 0, 0);
        repeat (3) tick();

        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.pout_valid, 0);
        chk("rst_pout", bus.pout, 0);
        chk("rst_ovr", bus.overrun, 0);
        chk("rst_perr", bus.parity_err, 0);
        bus.bit_stb = 1'b1;
        #1 chk("rst_shift_en", bus.shift_en, 0);
        bus.bit_stb = 1'b0;

`ifndef PARITY_CHECK_EN
        //          r  s  b  d  rd c   sh busy val pout     ovr
        tbl[0]  = '{1, 0, 1, 1, 0, 0,  0, 0, 0, 4'b0000, 0};
        tbl[1]  = '{0, 1, 1, 0, 0, 0,  0, 0, 0, 4'b0000, 0};
        tbl[2]  = '{0, 0, 1, 1, 1, 0,  1, 1, 0, 4'b0000, 0};
        tbl[3]  = '{0, 0, 1, 0, 1, 0,  1, 1, 0, 4'b0000, 0};
        tbl[4]  = '{0, 0, 1, 1, 1, 0,  1, 1, 0, 4'b0000, 0};
        tbl[5]  = '{0, 0, 1, 1, 1, 0,  1, 1, 0, 4'b0000, 0};
        tbl[6]  = '{0, 0, 0, 0, 1, 0,  0, 1, 0, 4'b0000, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 0,  0, 0, 1, 4'b1011, 0};
        tbl[8]  = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b1011, 0};
        tbl[9]  = '{0, 1, 0, 0, 0, 0,  0, 0, 0, 4'b1011, 0};
        tbl[10] = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 4'b1011, 0};
        tbl[11] = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 4'b1011, 0};
        tbl[12] = '{0, 0, 1, 1, 0, 0,  1, 1, 0, 4'b1011, 0};
        tbl[13] = '{0, 0, 1, 0, 0, 0,  1, 1, 0, 4'b1011, 0};
        tbl[14] = '{0, 0, 0, 0, 0, 0,  0, 1, 0, 4'b1011, 0};
        tbl[15] = '{0, 1, 0, 0, 0, 0,  0, 0, 1, 4'b0110, 0};
        tbl[16] = '{0, 0, 1, 1, 0, 0,  1, 1, 1, 4'b0110, 0};
        tbl[17] = '{0, 0, 1, 0, 0, 0,  1, 1, 1, 4'b0110, 0};
        tbl[18] = '{0, 0, 1, 0, 0, 0,  1, 1, 1, 4'b0110, 0};
        tbl[19] = '{0, 0, 1, 1, 0, 0,  1, 1, 1, 4'b0110, 0};
        tbl[20] = '{0, 0, 0, 0, 0, 0,  0, 1, 1, 4'b0110, 0};
        tbl[21] = '{0, 0, 0, 0, 1, 0,  0, 0, 1, 4'b0110, 1};
        tbl[22] = '{0, 0, 0, 0, 0, 1,  0, 0, 0, 4'b0110, 1};
        tbl[23] = '{0, 0, 0, 0, 0, 0,  0, 0, 0, 4'b0110, 0};
        for (int i = 0; i < 24; i++) begin
            drv(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].d, tbl[i].rd, tbl[i].c);
            #1;
            chk($sformatf("row%0d_shift_en", i), bus.shift_en, tbl[i].sh);
            chk($sformatf("row%0d_busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("row%0d_valid", i), bus.pout_valid, tbl[i].val);
            chk($sformatf("row%0d_pout", i), bus.pout, tbl[i].pout);
            chk($sformatf("row%0d_ovr", i), bus.overrun, tbl[i].ovr);
            chk($sformatf("row%0d_perr", i), bus.parity_err, 0);
            tick();
        end
`endif

        // Capture and accept in the same cycle
        send_frame(4'b0101, 1'b0, 1'b0);
        chk("cap1_valid", bus.pout_valid, 1);
        chk("cap1_pout", bus.pout, 4'b0101);
        send_frame(4'b1110, 1'b1, 1'b1);
        chk("cap2_valid", bus.pout_valid, 1);
        chk("cap2_pout", bus.pout, 4'b1110);
        chk("cap2_ovr", bus.overrun, 0);
        drv(0, 0, 0, 0, 1, 0); tick();
        chk("drain_valid", bus.pout_valid, 0);
        drv(0, 0, 0, 0, 0, 0); tick();

        // Restart mid-frame; the restart cycle's strobe must not shift
        base = sh_cnt;
        drv(0, 1, 0, 0, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        drv(0, 1, 1, 1, 0, 0);
        #1 chk("restart_shift_en", bus.shift_en, 0);
        tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        drv(0, 0, 1, 1, 0, 0); tick();
        drv(0, 0, 1, 0, 0, 0); tick();
        drv(0, 0, 1, 0, 0, 0); tick();
`ifdef PARITY_CHECK_EN
        drv(0, 0, 1, 0, 0, 0); tick();
`endif
        drv(0, 0, 0, 0, 0, 0); tick();
        tick();
        chk("restart_pout", bus.pout, 4'b1100);
        chk("restart_valid", bus.pout_valid, 1);
        chk("restart_shifts", sh_cnt - base, 6);

        // Overrun while full, then reset mid-frame clears everything
        send_frame(4'b1111, 1'b0, 1'b0);
        chk("ovr2_pout", bus.pout, 4'b1100);
        chk("ovr2_ovr", bus.overrun, 1);
        drv(0, 1, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 1, 1, 0, 0); tick();
        end
        drv(1, 0, 1, 1, 0, 0);
        #1 chk("midrst_shift_en", bus.shift_en, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0);
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_valid", bus.pout_valid, 0);
        chk("midrst_pout", bus.pout, 0);
        chk("midrst_ovr", bus.overrun, 0);
        chk("midrst_perr", bus.parity_err, 0);
        tick();
        base = sh_cnt;
        send_frame(4'b0011, 1'b0, 1'b1);
        chk("fresh_pout", bus.pout, 4'b0011);
        chk("fresh_valid", bus.pout_valid, 1);
        chk("fresh_shifts", sh_cnt - base, 4);

        // Parity: ^1011 = 1, so parity_bit=1 is good and 0 is bad
        base = sh_cnt;
        send_frame(4'b1011, 1'b1, 1'b1);
        chk("par1_pout", bus.pout, 4'b1011);
        chk("par1_perr", bus.parity_err, 0);
        chk("par1_shifts", sh_cnt - base, 4);
        base = sh_cnt;
        send_frame(4'b1011, 1'b0, 1'b1);
        chk("par0_pout", bus.pout, 4'b1011);
`ifdef PARITY_CHECK_EN
        chk("par0_perr", bus.parity_err, 1);
`else
        chk("par0_perr", bus.parity_err, 0);
`endif
        chk("par0_shifts", sh_cnt - base, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stop_frame_ctrl.md
Name: stop_frame_ctrl

Overview:
- Controller that sequences the team's WIDTH-bit serial-to-parallel shift register (D flip-flop chain).
- Detects frame start and gates the register's shift enable, one pulse per incoming bit.
- Counts bits and captures the completed parallel word into a holding register.
- Presents the word downstream with a valid/ready handshake and flags overruns.

Parameters:
- WIDTH, 4, bits per frame; equals the external shift-register length; legal range 2..16.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle frame-start strobe.
- bit_stb  in  1  marks a valid serial bit on the shift register's input this cycle.
- sreg_q  in  WIDTH  parallel outputs of the external shift register.
- shift_en  out  1  shift enable to the external register (combinational).
- pout  out  WIDTH  captured parallel word.
- pout_valid  out  1  pout holds an unconsumed word.
- pout_ready  in  1  downstream accepts pout.
- busy  out  1  high while in SHIFT or CAPT.
- overrun  out  1  sticky; a word was lost because the holder was full.
- ovr_clr  in  1  clears overrun.
- parity_bit  in  1  received parity bit; used only with PARITY_CHECK_EN.
- parity_err  out  1  parity status of pout; used only with PARITY_CHECK_EN.

Behaviour:
- Reset values: state=IDLE, bit count=0, pout=0, pout_valid=0, overrun=0, parity_err=0, busy=0. shift_en=0 while rst is high.
- Reset mid-frame aborts the frame and leaves no partial capture.
- Bit counter width is $clog2(WIDTH+1) and it never wraps past WIDTH.
- IDLE:
  - start=1 -> SHIFT with count=0.
  - bit_stb is ignored in IDLE, including in the start cycle.
- SHIFT:
  - shift_en = bit_stb.
  - Each bit_stb increments count.
  - When the strobe that makes count reach WIDTH occurs -> CAPT.
  - start=1 in SHIFT restarts the frame: count=0, stay in SHIFT, and that cycle's bit_stb is ignored (shift_en=0).
- CAPT (one cycle; sreg_q now holds the full word):
  - shift_en=0.
  - If pout_valid=0, or pout_ready=1 this cycle: pout<=sreg_q, pout_valid<=1.
  - Otherwise keep the old pout, set overrun<=1, and discard the new word.
  - Then -> IDLE. A start in CAPT is ignored.
- Handshake:
  - A transfer occurs when pout_valid & pout_ready.
  - Transfer without a simultaneous capture -> pout_valid<=0.
  - pout is stable while pout_valid=1.
- Capture-to-valid latency: pout_valid rises 2 cycles after the final bit_stb (1 edge to shift, 1 to capture).
- overrun:
  - Set has priority over ovr_clr in the same cycle.
  - Cleared only by ovr_clr or rst.
- busy = (state != IDLE).

Optional Feature:
PARITY_CHECK_EN:
- Defined:
  - Frame is WIDTH data bits plus one parity bit; the parity bit arrives on parity_bit with the (WIDTH+1)th bit_stb.
  - shift_en is not asserted for the parity strobe.
  - CAPT is entered after the parity strobe.
  - parity_err <= (^sreg_q) ^ parity_bit (even parity) and is loaded together with pout.
  - On overrun, parity_err keeps its old value.
- Undefined:
  - Frame is WIDTH bits; parity_bit is ignored; parity_err is constant 0.

Test Plan:
- Bench model: sreg_q is a shift-left register with the serial bit entering bit 0, clocked by shift_en. All scenarios use WIDTH=4.
- Basic frame: rst, start, then bits 1,0,1,1 on 4 bit_stb cycles, pout_ready=1 -> shift_en pulses exactly 4 times; pout=4'b1011 and pout_valid=1 two cycles after the last strobe, then low next cycle; busy high from start+1 until CAPT ends.
- Backpressure/overrun: pout_ready=0, send frames 0110 then 1001 -> pout stays 4'b0110 and overrun=1. Then pout_ready=1 for 1 cycle -> pout_valid=0; ovr_clr -> overrun=0.
- Capture and accept in the same cycle: pout_valid=1 with pout_ready=1 in the CAPT cycle -> new word loaded, pout_valid stays 1, overrun stays 0.
- Restart and ignore rules: start, 2 bits, start again, then 4 bits 1100 -> pout=4'b1100 and exactly 6 shift_en pulses. A bit_stb asserted with start in IDLE produces no shift_en.
- Reset mid-frame: rst asserted after 3 bits -> next cycle all outputs are at reset values. A fresh 4-bit frame 0011 captures correctly.
- PARITY_CHECK_EN defined: data 1011 with parity_bit=1 -> parity_err=0. Data 1011 with parity_bit=0 -> parity_err=1. 4 shift_en pulses per frame in both cases.
